// File: rtl/ticket_printer_arb.sv
// Purpose: round-robin arbiter sharing one ticket printer among N_REQ ticket windows.
// Latency: req sampled in IDLE -> gnt next cycle, prn_start 2 cycles later, ack at earliest 4 cycles after sampling.
// Backpressure: req is a held level; losers wait for the next IDLE; a silent printer is cut off after TIMEOUT cycles.
// Optional feature: define TICKET_STOCK_EN for per-class stock counters (stock port is 0 otherwise).
module ticket_printer_arb #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
`ifdef TICKET_STOCK_EN
    ,
    parameter int STOCK0  = 8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] cls,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   nack,
    output logic               prn_start,
    output logic [1:0]         prn_cls,
    input  logic               prn_done,
    output logic               err,
    output logic [23:0]        stock
);
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, CHK, START, WAIT, DONE, FAIL} state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   sel;
    logic [LW-1:0]   pick;
    logic [LW-1:0]   cand;
    logic            found;
    logic [1:0]      cls_q;
    logic [TO_W-1:0] timer;
    logic            can_print;

    // Round-robin search starting just after the last served window
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef TICKET_STOCK_EN
    logic [2:0][7:0] stock_q;
    logic [7:0]      cur_stock;

    // Remaining stock of the latched class (class 0 has no stock)
    always_comb begin
        case (cls_q)
            2'd1:    cur_stock = stock_q[0];
            2'd2:    cur_stock = stock_q[1];
            2'd3:    cur_stock = stock_q[2];
            default: cur_stock = 8'd0;
        endcase
    end

    assign can_print = (cls_q != 2'd0) && (cur_stock != 8'd0);
    assign stock     = stock_q;

    // Stock counters: reload on reset, one ticket consumed per completed print, floor at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            stock_q <= {3{8'(STOCK0)}};
        end else if (state == DONE) begin
            for (int i = 0; i < 3; i++) begin
                if (cls_q == 2'(i + 1) && stock_q[i] != 8'd0) begin
                    stock_q[i] <= stock_q[i] - 8'd1;
                end
            end
        end
    end
`else
    assign can_print = (cls_q != 2'd0);
    assign stock     = '0;
`endif

    // Transaction sequencer: grant, class check, printer handshake with timeout, ack/nack
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LW'(N_REQ - 1);
            sel       <= '0;
            cls_q     <= '0;
            timer     <= '0;
            gnt       <= '0;
            ack       <= '0;
            nack      <= '0;
            prn_start <= 1'b0;
            prn_cls   <= '0;
            err       <= 1'b0;
        end else begin
            ack       <= '0;
            nack      <= '0;
            prn_start <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        cls_q <= cls[2*pick +: 2];
                        gnt   <= N_REQ'(1) << pick;
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (!can_print) begin
                        nack  <= gnt;
                        gnt   <= '0;
                        state <= FAIL;
                    end else begin
                        prn_start <= 1'b1;
                        prn_cls   <= cls_q;
                        state     <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // completion wins over a timeout in the same cycle
                    if (prn_done) begin
                        ack   <= gnt;
                        gnt   <= '0;
                        state <= DONE;
                    end else if (timer == TO_W'(TIMEOUT - 1)) begin
                        nack  <= gnt;
                        gnt   <= '0;
                        err   <= 1'b1;
                        state <= FAIL;
                    end else begin
                        timer <= timer + TO_W'(1);
                    end
                end
                DONE, FAIL: begin
                    last    <= sel;
                    prn_cls <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ticket_printer_arb.sv
// Bench for ticket_printer_arb: directed scenarios plus random traffic.
// A transaction-level model predicts grant/start/end events into a queue;
// a monitor pops and compares whenever the arbiter shows activity.
module tb_ticket_printer_arb;
    localparam int N       = 3;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;
`ifdef TICKET_STOCK_EN
    localparam int STOCK0  = 2;
`endif

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [2*N-1:0] cls      = '0;
    logic           prn_done = 1'b0;
    logic [N-1:0]   gnt, ack, nack;
    logic           prn_start, err;
    logic [1:0]     prn_cls;
    logic [23:0]    stock;

    ticket_printer_arb #(
        .N_REQ(N), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
`ifdef TICKET_STOCK_EN
        , .STOCK0(STOCK0)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cls(cls), .gnt(gnt), .ack(ack), .nack(nack),
        .prn_start(prn_start), .prn_cls(prn_cls), .prn_done(prn_done), .err(err), .stock(stock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic [N-1:0] nack;
        logic         start;
        logic         err;
        logic [1:0]   pcls;
        logic         chk_cls;
        logic         chk_stock;
        logic [23:0]  stock;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    // reference model state
    int last_m = N - 1;
    int stock_m[3];

    function automatic ev_t mk_ev(input int at, input logic [N-1:0] g, input logic [N-1:0] a,
                                  input logic [N-1:0] na, input logic st, input logic er,
                                  input logic [1:0] pc, input logic cc, input logic cs,
                                  input logic [23:0] sk);
        ev_t x;
        x.at = at; x.gnt = g; x.ack = a; x.nack = na; x.start = st; x.err = er;
        x.pcls = pc; x.chk_cls = cc; x.chk_stock = cs; x.stock = sk;
        return x;
    endfunction

    function automatic logic [23:0] stock_exp();
`ifdef TICKET_STOCK_EN
        return {8'(stock_m[2]), 8'(stock_m[1]), 8'(stock_m[0])};
`else
        return 24'd0;
`endif
    endfunction

    function automatic bit class_ok(input logic [1:0] c);
`ifdef TICKET_STOCK_EN
        return (c != 2'd0) && (stock_m[int'(c) - 1] > 0);
`else
        return c != 2'd0;
`endif
    endfunction

    function automatic int winner();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_m + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // monitor: compare every visible arbiter event against the predicted queue
    ev_t          e_m;
    logic [N-1:0] gnt_prev = '0;
    logic         seen;
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e_m = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_event due=%0d now=%0d want gnt=%b ack=%b nack=%b start=%b err=%b",
                         e_m.at, cyc, e_m.gnt, e_m.ack, e_m.nack, e_m.start, e_m.err);
            end
            seen = prn_start || (|ack) || (|nack) || err || (gnt != gnt_prev && gnt != '0);
            if (seen) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event cyc=%0d gnt=%b ack=%b nack=%b start=%b err=%b",
                             cyc, gnt, ack, nack, prn_start, err);
                end else begin
                    e_m = exp_q.pop_front();
                    if (e_m.at != cyc || gnt !== e_m.gnt || ack !== e_m.ack || nack !== e_m.nack ||
                        prn_start !== e_m.start || err !== e_m.err ||
                        (e_m.chk_cls && prn_cls !== e_m.pcls) ||
                        (e_m.chk_stock && stock !== e_m.stock)) begin
                        n_err++;
                        $display("FAIL event got cyc=%0d gnt=%b ack=%b nack=%b start=%b err=%b cls=%0d stock=%h want cyc=%0d gnt=%b ack=%b nack=%b start=%b err=%b cls=%0d stock=%h",
                                 cyc, gnt, ack, nack, prn_start, err, prn_cls, stock,
                                 e_m.at, e_m.gnt, e_m.ack, e_m.nack, e_m.start, e_m.err, e_m.pcls, e_m.stock);
                    end
                end
            end
        end
        gnt_prev = gnt;
    end

    // hold reset two cycles, check reset outputs, then release in the current cycle
    task automatic do_reset();
        rst = 1'b1; req = '0; cls = '0; prn_done = 1'b0;
        next();
        next();
        last_m = N - 1;
        for (int i = 0; i < 3; i++) begin
`ifdef TICKET_STOCK_EN
            stock_m[i] = STOCK0;
`else
            stock_m[i] = 0;
`endif
        end
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack_nack", 32'({ack, nack}), 32'd0);
        check("rst_start_err", 32'({prn_start, err}), 32'd0);
        check("rst_prn_cls", 32'(prn_cls), 32'd0);
        check("rst_stock", 32'(stock), 32'(stock_exp()));
        rst = 1'b0;
    endtask

    // mid-transaction disturbance: winner's class/req change, other windows may join
    task automatic disturb(input int w);
        cls[2*w +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i != w && !req[i] && $urandom_range(0, 1) == 1) begin
                req[i] = 1'b1;
                cls[2*i +: 2] = 2'($urandom_range(1, 3));
            end
        end
    endtask

    // one arbitration round starting in the current (IDLE) cycle; d = printer delay after prn_start
    task automatic txn(input int d, input bit keep, input bit mid);
        int c, w, e;
        bit ok;
        logic [1:0] wc;
        logic [N-1:0] oh;
        c = cyc;
        w = winner();
        if (w < 0) begin
            next();
            return;
        end
        wc = cls[2*w +: 2];
        oh = N'(1) << w;
        ok = class_ok(wc);
        exp_q.push_back(mk_ev(c + 1, oh, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, stock_exp()));
        if (ok) begin
            exp_q.push_back(mk_ev(c + 2, oh, '0, '0, 1'b1, 1'b0, wc, 1'b1, 1'b0, 24'd0));
            if (d <= TIMEOUT) begin
                e = c + 3 + d;
                exp_q.push_back(mk_ev(e, '0, oh, '0, 1'b0, 1'b0, wc, 1'b1, 1'b0, 24'd0));
            end else begin
                e = c + 3 + TIMEOUT;
                exp_q.push_back(mk_ev(e, '0, '0, oh, 1'b0, 1'b1, wc, 1'b1, 1'b0, 24'd0));
            end
        end else begin
            e = c + 2;
            exp_q.push_back(mk_ev(e, '0, '0, oh, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 24'd0));
        end
        while (cyc < e) begin
            next();
            prn_done = 1'b0;
            if (cyc <= c + 2 || cyc == e) prn_done = ($urandom_range(0, 3) == 0);
            if (ok && d <= TIMEOUT && cyc == c + 2 + d) prn_done = 1'b1;
            if (mid && cyc == c + 1) disturb(w);
            if (cyc == e && !keep) req[w] = 1'b0;
        end
        last_m = w;
`ifdef TICKET_STOCK_EN
        if (ok && d <= TIMEOUT) stock_m[int'(wc) - 1] = stock_m[int'(wc) - 1] - 1;
`endif
        next();
        prn_done = 1'b0;
    endtask

    task automatic add_reqs();
        int r;
        for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i] = 1'b1;
                r = $urandom_range(0, 7);
                cls[2*i +: 2] = (r == 0) ? 2'd0 : 2'(1 + r % 3);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    int tc, tw, d, dsel;
    initial begin
        do_reset();
`ifdef TICKET_STOCK_EN
        // three class-3 prints from window 2 against a stock of two
        req = 3'b100; cls = 6'b11_00_00;
        txn(2, 1, 0);
        txn(2, 1, 0);
        txn(2, 0, 0);
        check("stock_c3_empty", 32'(stock[23:16]), 32'd0);
`endif
        // fairness: all three hold requests, printer answers after one cycle
        req = 3'b111; cls = {2'd2, 2'd2, 2'd1};
        txn(1, 1, 0);
        txn(1, 1, 0);
        txn(1, 1, 0);
        txn(1, 0, 0);
        req = '0;
        do_reset();
        // single request from window 1, class 2, done 4 cycles after start
        req = 3'b010; cls = 6'b00_10_00;
        txn(4, 0, 0);
        // printer never answers
        req = 3'b001; cls = 6'b00_00_01;
        txn(TIMEOUT + 4, 0, 0);
        // invalid class from window 2
        req = 3'b100; cls = 6'b00_00_00;
        txn(3, 0, 0);
        // done on the last waiting cycle still wins, and one cycle earlier
        do_reset();
        req = 3'b001; cls = 6'b00_00_01;
        txn(TIMEOUT, 0, 0);
        req = 3'b010; cls = 6'b00_10_00;
        txn(TIMEOUT - 1, 0, 0);
        // reset while waiting on the printer: no ack, pointer back to window 0 first
        do_reset();
        req = 3'b001; cls = 6'b00_00_01;
        tc = cyc;
        tw = winner();
        exp_q.push_back(mk_ev(tc + 1, N'(1) << tw, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, stock_exp()));
        exp_q.push_back(mk_ev(tc + 2, N'(1) << tw, '0, '0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 24'd0));
        while (cyc < tc + 4) next();
        do_reset();
        req = 3'b011; cls = 6'b00_10_01;
        txn(2, 0, 0);
        txn(2, 0, 0);
        // random traffic
        for (int r = 0; r < 200; r++) begin
            if (r % 50 == 49) do_reset();
            add_reqs();
            dsel = $urandom_range(0, 9);
            if (dsel < 7)       d = $urandom_range(1, 5);
            else if (dsel == 7) d = TIMEOUT;
            else if (dsel == 8) d = TIMEOUT - 1;
            else                d = TIMEOUT + 3;
            txn(d, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end
        req = '0;
        repeat (5) next();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
